// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four hex digits onto a common-anode
// seven-segment display.
//   CLK            - single clock, rising edge
//   RESET          - asynchronous, active-low
//   lowerDigits    - {digit1, digit0}
//   upperDigits    - {digit3, digit2}
//   dotMask        - bit n lights the decimal point of digit n
//   SEG_SELECT_OUT - active-low anodes, bit n = digit n
//   HEX_OUT        - active-low cathodes {DP,g,f,e,d,c,b,a}
//   frameTick      - one-cycle pulse after each shadow-register load
// Inputs are captured into a shadow register only at the frame boundary so a
// frame never mixes old and new digits. Every slot starts with BLANK_CYCLES
// of all-anodes-off so the previous digit's pattern cannot ghost onto the next.

// Per-digit decoder: nibble -> active-low segments, with blanking and DP.
module seven_seg_lane (
    input  logic [3:0] nib,
    input  logic       dot,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [7:0] glyph;

    always_comb begin
        glyph = 8'hFF;
        unique case (nib)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            4'hF: glyph = 8'h8E;
        endcase
    end

    // A blanked digit still shows its decimal point.
    always_comb begin
        seg    = blank ? 8'hFF : glyph;
        seg[7] = ~dot & seg[7];
    end
endmodule

module seven_seg_scanner #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZB          = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] lowerDigits,
    input  logic [7:0] upperDigits,
    input  logic [3:0] dotMask,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT,
    output logic       frameTick
);
    localparam int              NUM_DIGITS = 4;
    localparam int              CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam bit              LZB_EN     = (LZB != 0);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    // Shadow copy of the display contents, one nibble / dot per digit.
    logic [NUM_DIGITS-1:0][3:0] sh_dig;
    logic [NUM_DIGITS-1:0]      sh_dot;

    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0][7:0] seg_lane;

    logic wrap, frame_end;
    assign wrap      = (cnt == CNT_MAX);
    assign frame_end = wrap && (idx == 2'd3);

    // Leading-zero blanking cascades down from the most significant digit;
    // digit0 always shows so a value of zero still reads "0".
    always_comb begin
        blank    = '0;
        blank[3] = LZB_EN && (sh_dig[3] == 4'h0);
        blank[2] = blank[3] && (sh_dig[2] == 4'h0);
        blank[1] = blank[2] && (sh_dig[1] == 4'h0);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
            seven_seg_lane u_lane (
                .nib   (sh_dig[g]),
                .dot   (sh_dot[g]),
                .blank (blank[g]),
                .seg   (seg_lane[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt            <= '0;
            idx            <= 2'd0;
            sh_dig         <= '0;
            sh_dot         <= '0;
            frameTick      <= 1'b0;
            SEG_SELECT_OUT <= 4'hF;
            HEX_OUT        <= 8'hFF;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= idx + 2'd1;

            if (frame_end) begin
                sh_dig <= {upperDigits, lowerDigits};
                sh_dot <= dotMask;
            end
            frameTick <= frame_end;

            // Outputs reflect the (cnt, idx, shadow) state of this cycle,
            // so the shadow load shows up only from the next slot onward.
            if (cnt < BLANK_LIM) begin
                SEG_SELECT_OUT <= 4'hF;
                HEX_OUT        <= 8'hFF;
            end else begin
                SEG_SELECT_OUT <= ~(4'b0001 << idx);
                HEX_OUT        <= seg_lane[idx];
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] lo, up;
    logic [3:0] dm;
    logic [3:0] sel0, sel1;
    logic [7:0] hex0, hex1;
    logic       ft0, ft1;

    always #5 CLK = ~CLK;

    seven_seg_scanner #(.PRESCALE(P), .BLANK_CYCLES(B), .LZB(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .lowerDigits(lo), .upperDigits(up),
        .dotMask(dm), .SEG_SELECT_OUT(sel0), .HEX_OUT(hex0), .frameTick(ft0));

    seven_seg_scanner #(.PRESCALE(P), .BLANK_CYCLES(B), .LZB(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .lowerDigits(lo), .upperDigits(up),
        .dotMask(dm), .SEG_SELECT_OUT(sel1), .HEX_OUT(hex1), .frameTick(ft1));

    int n_tests = 0;
    int n_fail  = 0;
    int t;          // cycles since reset release, as seen at the sampled edge
    bit rand_en;

    // Reference model: what the display should currently be showing.
    logic [3:0] m_dig [4];
    logic [3:0] m_dot;
    logic [7:0] seg_tbl [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_sel(input int tt);
        int d;
        d = (tt / P) % 4;
        if (tt % P < B) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_hex(input int tt, input bit lzb);
        int d;
        bit bl;
        logic [7:0] h;
        d  = (tt / P) % 4;
        bl = 1'b0;
        if (tt % P < B) return 8'hFF;
        if (lzb) begin
            if (d == 3) bl = (m_dig[3] == 0);
            if (d == 2) bl = (m_dig[3] == 0) && (m_dig[2] == 0);
            if (d == 1) bl = (m_dig[3] == 0) && (m_dig[2] == 0) && (m_dig[1] == 0);
        end
        h = bl ? 8'hFF : seg_tbl[m_dig[d]];
        if (m_dot[d]) h[7] = 1'b0;
        return h;
    endfunction

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dot = 4'h0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        check("sel0", 32'(sel0), 32'(exp_sel(t)));
        check("sel1", 32'(sel1), 32'(exp_sel(t)));
        check("hex0", 32'(hex0), 32'(exp_hex(t, 1'b0)));
        check("hex1_lzb", 32'(hex1), 32'(exp_hex(t, 1'b1)));
        check("tick0", 32'(ft0), 32'((t % FRAME) == FRAME - 1));
        check("tick1", 32'(ft1), 32'((t % FRAME) == FRAME - 1));
        check("one_anode", 32'($countones(~sel0) <= 1), 32'd1);
        // Inputs present at this edge are what the frame boundary captures.
        if ((t % FRAME) == FRAME - 1) begin
            m_dig[0] = lo[3:0];
            m_dig[1] = lo[7:4];
            m_dig[2] = up[3:0];
            m_dig[3] = up[7:4];
            m_dot    = dm;
        end
        t++;
        if (rand_en && $urandom_range(0, 7) == 0) begin
            lo = {rnib(), rnib()};
            up = {rnib(), rnib()};
            dm = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel0"}, 32'(sel0), 32'hF);
        check({tag, "_sel1"}, 32'(sel1), 32'hF);
        check({tag, "_hex0"}, 32'(hex0), 32'hFF);
        check({tag, "_hex1"}, 32'(hex1), 32'hFF);
        check({tag, "_tick"}, 32'({ft0, ft1}), 32'h0);
    endtask

    initial begin
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        model_clear();
        rand_en = 1'b0;
        t  = 0;
        lo = 8'h21;
        up = 8'h43;
        dm = 4'h0;

        #12;
        check_reset_outputs("rst");
        #8 RESET = 1'b1;   // next rising edge starts slot 0

        // Frame 1 shows the reset shadow, frame 2 shows 4321.
        run(2 * FRAME);

        // Mid-frame change must wait for the next boundary.
        run(10);
        lo = 8'hFF;
        run(2 * FRAME);

        // Leading-zero blanking with a dot on a blanked digit.
        up = 8'h00;
        lo = 8'h05;
        dm = 4'b0100;
        run(2 * FRAME);
        up = 8'h00;
        lo = 8'h00;
        dm = 4'b0000;
        run(2 * FRAME);

        rand_en = 1'b1;
        run(3000);

        // Asynchronous reset in the middle of slot 2.
        while ((t % FRAME) < 2 * P + 3 || (t % FRAME) >= 3 * P) step();
        #2 RESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        #2 RESET = 1'b1;
        t = 0;
        rand_en = 1'b0;
        run(FRAME + 4);
        rand_en = 1'b1;
        run(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
